// File: rtl/crc10_frame_check.sv
// Purpose : receive-side CRC-10 frame checker; strips the CRC word, forwards data, reports a per-frame verdict.
// Latency : data word k leaves 1 cycle after the next accepted frame word; verdict 1 cycle after the terminating word.
// Backpr.  : none; one word accepted every cycle, in_valid gaps simply stall the pipeline.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   in_valid/in_sof/in_eof/in_data input words; the eof word carries the expected CRC in [9:0]
//   out_valid/out_data/out_sof/out_eof forwarded data words (CRC word removed)
//   frame_done/frame_ok/err_crc/err_len/err_proto per-frame verdict pulse and cause
//   err_cnt                       saturating count of failed frames

// One 15-bit step of CRC-10 (x^10+x^9+x^5+x^4+x+1), data taken MSB first.
module crc10_15bit (
    input  logic [14:0] data_in,
    input  logic [9:0]  lfsr_q,
    output logic [9:0]  lfsr_c
);
    localparam logic [9:0] POLY = 10'h233;

    logic [9:0] acc;
    logic       fb;

    always_comb begin
        acc = lfsr_q;
        fb  = 1'b0;
        for (int i = 14; i >= 0; i--) begin
            fb  = acc[9] ^ data_in[i];
            acc = {acc[8:0], 1'b0} ^ (POLY & {10{fb}});
        end
        lfsr_c = acc;
    end
endmodule

module crc10_frame_check #(
    parameter int         MAX_WORDS = 64,
    parameter logic [9:0] CRC_INIT  = 10'h000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        in_sof,
    input  logic        in_eof,
    input  logic [14:0] in_data,
    output logic        out_valid,
    output logic [14:0] out_data,
    output logic        out_sof,
    output logic        out_eof,
    output logic        frame_done,
    output logic        frame_ok,
    output logic        err_crc,
    output logic        err_len,
    output logic        err_proto,
    output logic [15:0] err_cnt
);
    localparam int            CW      = $clog2(MAX_WORDS + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_BODY, S_DISCARD} state_t;

    state_t        state_q, state_d;
    logic [9:0]    crc_q;
    logic [9:0]    crc_next;
    logic [9:0]    crc_seed;
    logic [14:0]   hold_dat;
    logic          hold_first;
    logic [CW-1:0] word_cnt;
    logic          cnt_at_max;

    // Decoded per-cycle actions
    logic emit_d, emit_sof_d, emit_eof_d;
    logic done_d, ok_d, ecrc_d, elen_d, eproto_d;
    logic hold_ld, hold_first_d;
    logic crc_ld, crc_rst;
    logic cnt_first, cnt_inc;

    // Outside BODY the register already sits at CRC_INIT; the explicit seed
    // keeps a new frame independent of that invariant.
    assign crc_seed   = (state_q == S_BODY) ? crc_q : CRC_INIT;
    assign cnt_at_max = (word_cnt == MAX_CNT);

    crc10_15bit u_step (
        .data_in (in_data),
        .lfsr_q  (crc_seed),
        .lfsr_c  (crc_next)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (in_valid) begin
            case (state_q)
                S_IDLE, S_DISCARD: begin
                    if (in_sof)
                        state_d = in_eof ? S_IDLE : S_BODY;
                    else if (in_eof && state_q == S_DISCARD)
                        state_d = S_IDLE;
                end
                S_BODY: begin
                    if (in_sof || in_eof) state_d = S_IDLE;
                    else if (cnt_at_max)  state_d = S_DISCARD;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Action decode
    always_comb begin
        emit_d       = 1'b0;
        emit_sof_d   = 1'b0;
        emit_eof_d   = 1'b0;
        done_d       = 1'b0;
        ok_d         = 1'b0;
        ecrc_d       = 1'b0;
        elen_d       = 1'b0;
        eproto_d     = 1'b0;
        hold_ld      = 1'b0;
        hold_first_d = 1'b0;
        crc_ld       = 1'b0;
        crc_rst      = 1'b0;
        cnt_first    = 1'b0;
        cnt_inc      = 1'b0;
        if (in_valid) begin
            case (state_q)
                S_IDLE, S_DISCARD: begin
                    if (in_sof && in_eof) begin
                        // Zero-data frame: the CRC of nothing is the seed.
                        done_d = 1'b1;
                        ok_d   = (CRC_INIT == in_data[9:0]);
                        ecrc_d = ~ok_d;
                    end else if (in_sof) begin
                        hold_ld      = 1'b1;
                        hold_first_d = 1'b1;
                        crc_ld       = 1'b1;
                        cnt_first    = 1'b1;
                    end
                end
                S_BODY: begin
                    // Every accepted word in BODY releases the held word.
                    emit_d     = 1'b1;
                    emit_sof_d = hold_first;
                    if (in_sof) begin
                        emit_eof_d = 1'b1;
                        done_d     = 1'b1;
                        eproto_d   = 1'b1;
                        crc_rst    = 1'b1;
                    end else if (in_eof) begin
                        emit_eof_d = 1'b1;
                        done_d     = 1'b1;
                        ok_d       = (crc_q == in_data[9:0]);
                        ecrc_d     = ~ok_d;
                        crc_rst    = 1'b1;
                    end else if (cnt_at_max) begin
                        emit_eof_d = 1'b1;
                        done_d     = 1'b1;
                        elen_d     = 1'b1;
                        crc_rst    = 1'b1;
                    end else begin
                        hold_ld = 1'b1;
                        crc_ld  = 1'b1;
                        cnt_inc = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath: CRC register, one-word buffer, word counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_q      <= CRC_INIT;
            hold_dat   <= '0;
            hold_first <= 1'b0;
            word_cnt   <= '0;
        end else begin
            if (crc_rst)     crc_q <= CRC_INIT;
            else if (crc_ld) crc_q <= crc_next;
            if (hold_ld) begin
                hold_dat   <= in_data;
                hold_first <= hold_first_d;
            end
            if (cnt_first)    word_cnt <= CW'(1);
            else if (cnt_inc) word_cnt <= word_cnt + CW'(1);
        end
    end

    // Registered outputs; pulses clear every cycle, data fields hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_sof    <= 1'b0;
            out_eof    <= 1'b0;
            frame_done <= 1'b0;
            frame_ok   <= 1'b0;
            err_crc    <= 1'b0;
            err_len    <= 1'b0;
            err_proto  <= 1'b0;
            err_cnt    <= '0;
        end else begin
            out_valid  <= emit_d;
            frame_done <= done_d;
            frame_ok   <= ok_d;
            err_crc    <= ecrc_d;
            err_len    <= elen_d;
            err_proto  <= eproto_d;
            if (emit_d) begin
                out_data <= hold_dat;
                out_sof  <= emit_sof_d;
                out_eof  <= emit_eof_d;
            end
            if (done_d && !ok_d && err_cnt != 16'hFFFF)
                err_cnt <= err_cnt + 16'd1;
        end
    end
endmodule

// File: doc/crc10_frame_check.md
# crc10_frame_check

Receive-side frame checker directly downstream of the decoder's 15-bit word output. It runs the CRC-10 (1+x+x^4+x^5+x^9+x^10) over each frame's data words, 15 bits per cycle, by instantiating the existing `crc10_15bit` step. It compares the result with the CRC carried in the frame's final word. Data words are forwarded with the CRC word stripped, and a per-frame pass/fail verdict is reported alongside an error counter.

## Interface
- `MAX_WORDS`, 64: maximum data words per frame, excluding the CRC word; must be ≥ 1.
- `CRC_INIT`, 10'h000: CRC register seed at the start of each frame.
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: input word qualifier.
- `in_sof` in 1: first word of a frame; qualified by `in_valid`.
- `in_eof` in 1: CRC word (last of frame); `in_data[9:0]` holds the expected CRC, `[14:10]` ignored.
- `in_data` in 15: input word.
- `out_valid` out 1: forwarded data word valid.
- `out_data` out 15: forwarded data word.
- `out_sof` / `out_eof` out 1: first / last data word of the forwarded frame.
- `frame_done` out 1: one-cycle verdict pulse.
- `frame_ok` out 1: high with `frame_done` when the CRC matched and there was no error.
- `err_crc`, `err_len`, `err_proto` out 1: error cause, valid with `frame_done`.
- `err_cnt` out 16: count of failed frames, saturating at 16'hFFFF.

## Operation
- **Per-word update:** `crc_next = crc10_15bit(data_in = in_data, lfsr_q = crc_reg)`.
  - `crc_reg` loads `crc_next` on each accepted data word.
  - `crc_reg` reloads `CRC_INIT` when a frame ends or is aborted.
- **IDLE:**
  - `in_valid & in_sof & !in_eof`: the word is data. Hold it in the one-word buffer, set `crc_reg = step(word, CRC_INIT)`, set the word count to 1, go to BODY.
  - `in_valid & in_sof & in_eof`: zero-data frame. Compare `CRC_INIT` with `in_data[9:0]`, issue the verdict, stay in IDLE.
  - Valid words without `in_sof`: dropped silently.
- **BODY, data word** (`in_valid`, neither `sof` nor `eof`):
  - Emit the held word (`out_sof` = 1 if it was the frame's first word) and hold the new word.
  - Update the CRC and increment the count.
  - If the count is already `MAX_WORDS`, abort instead: emit the held word with `out_eof` = 1, issue the verdict with `err_len` = 1, and go to DISCARD. The new word is dropped.
- **BODY, `in_eof` without `in_sof`:**
  - Emit the held word with `out_eof` = 1.
  - Issue the verdict with `frame_ok = (crc_reg == in_data[9:0])` and `err_crc = !frame_ok`.
  - Go to IDLE.
- **BODY, `in_sof`** (with or without `eof`): protocol abort.
  - Emit the held word with `out_eof` = 1 and issue the verdict with `err_proto` = 1.
  - The `sof` word is dropped. Go to IDLE.
- **DISCARD:**
  - Drop all words until `in_eof` (that word is dropped too), then go to IDLE.
  - `in_sof` in DISCARD starts a new frame exactly as from IDLE.
  - No second verdict is issued for the discarded frame.
- **`err_cnt`:** increments on every `frame_done` with `frame_ok` = 0; it holds at 16'hFFFF.
- **`in_valid` = 0:** no state, CRC, buffer or output change beyond clearing the output pulses.

## Timing
- **Reset:** all outputs 0, `err_cnt` = 0, state IDLE, `crc_reg = CRC_INIT`, buffer empty.
  - Reset mid-frame discards the frame with no verdict and no `out_eof`.
- **Output registers:** all outputs are registered.
  - `out_valid`, `frame_done` and the error flags are single-cycle pulses, 0 when not asserted.
  - `out_data`/`out_sof`/`out_eof` hold their last values when `out_valid` = 0.
- **Data word latency:** data word k appears on the output 1 cycle after the edge that accepts the next frame word (k+1, the CRC word, or an aborting `sof`). Latency is variable and depends on `in_valid` gaps.
- **Verdict latency:** `frame_done` is asserted 1 cycle after the terminating word, on the same cycle as the last data word's `out_eof` (if one exists). `err_cnt` updates on the same edge.
- **Exclusivity:** at most one of `err_crc`/`err_len`/`err_proto` is high; all are 0 when `frame_ok` = 1.
- **Throughput:** one word per cycle, no backpressure; the block must accept every cycle.

## Test plan
- **Single good word:** `CRC_INIT` = 0; frame `sof`+0x0001, then `eof` with CRC 0x233 → next cycle `out_valid`, data 0x0001, `out_sof` = `out_eof` = 1, `frame_done`, `frame_ok` = 1, `err_cnt` = 0.
- **Single bad CRC:** same frame but CRC word 0x232 → `frame_ok` = 0, `err_crc` = 1, `err_cnt` = 1; data is still forwarded with `out_eof`.
- **Zero-data frame:** `sof`+`eof` with data 0x000 → `frame_done`, `frame_ok` = 1, no `out_valid`. Repeat with data 0x001 → `err_crc` = 1.
- **Length overflow:** `MAX_WORDS` = 4; `sof` + 4 zero words + 5th zero word + 3 words + `eof`.
  - Required: 4 words out with `out_eof` on the 4th; `err_len` = 1.
  - The following words through `eof` are dropped with no second verdict.
- **Protocol abort:** `sof`, 0x0001, 0x0002, then `sof` → words 0x0001 and 0x0002 out (`eof` on 0x0002), `err_proto` = 1, state IDLE. The next non-`sof` word is dropped.
- **Idle gaps and reset:** a good 3-word frame with `in_valid` gaps gives an identical verdict. Asserting `rst` after word 2 gives all outputs 0, no verdict, and `err_cnt` = 0. Forcing 65535+ bad frames (or preloading the counter) shows `err_cnt` saturating at 16'hFFFF.
